// File: rtl/mul_seq_pkg.sv
// Shared definitions for the sequential shift-add multiplier controller.
package mul_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    // Plain-vector state codes for legacy consumers that compare raw bits.
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_BUSY = BUSY;
    localparam logic [1:0] ST_DONE = DONE;

    localparam int MUL_ITERS = 32;
    localparam int CNT_W     = $clog2(MUL_ITERS);

endpackage

// File: rtl/mul_seq_ctrl_adder.sv
// Existing 32-bit shared adder; sum only, carry is recovered by the caller.
module mul_seq_ctrl_adder (
    input  logic [31:0] inp1,
    input  logic [31:0] inp2,
    output logic [31:0] out
);

    assign out = inp1 + inp2;

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential unsigned multiplier: one shift-add iteration per cycle, 32 cycles per product.
import mul_seq_pkg::*;

module mul_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITERS - 1);

    logic [1:0]           state;
    logic [WIDTH-1:0]     m;
    logic [2*WIDTH-1:0]   p;
    logic [CNT_W-1:0]     cnt;

    logic [WIDTH-1:0]     p_hi;
    logic [WIDTH-1:0]     sum;
    logic                 add_c;
    logic [WIDTH-1:0]     add_s;

    assign p_hi = p[2*WIDTH-1:WIDTH];

    mul_seq_ctrl_adder u_adder (
        .inp1 (p_hi),
        .inp2 (m),
        .out  (sum)
    );

    // Carry recovered by wrap detection so the shared adder stays the only adder here.
    assign add_c = p[0] ? (sum < p_hi) : 1'b0;
    assign add_s = p[0] ? sum : p_hi;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            m     <= '0;
            p     <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_valid) begin
                        m     <= op_a;
                        p     <= {{WIDTH{1'b0}}, op_b};
                        cnt   <= '0;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    p   <= {add_c, add_s, p[WIDTH-1:1]};
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) state <= ST_DONE;
                end
                ST_DONE: begin
                    if (res_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign start_ready = (state == ST_IDLE);
    assign busy        = (state == ST_BUSY);
    assign res_valid   = (state == ST_DONE);
    assign result      = p;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl with a cycle-level reference model and literal spot checks.
module tb_mul_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [63:0] result;
    logic        busy;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit chk_en    = 1'b0;

    mul_seq_ctrl #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .result      (result),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        else
            pass_cnt++;
    endtask

    // Reference model: an accepted request becomes a product that appears 32 edges later.
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    int          m_left = 0;
    logic [63:0] m_pend = '0;
    logic [63:0] m_res  = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_res  = '0;
        end else if (m_done) begin
            if (res_ready) m_done = 1'b0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                m_res  = m_pend;
            end
        end else if (start_valid) begin
            m_busy = 1'b1;
            m_left = 32;
            m_pend = 64'(op_a) * 64'(op_b);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("start_ready", 64'(start_ready), 64'(!m_busy && !m_done));
            check("busy",        64'(busy),        64'(m_busy));
            check("res_valid",   64'(res_valid),   64'(m_done));
            if (!m_busy) check("result", result, m_res);
        end
    end

    // Accept one request and return at the negedge where res_valid is first seen.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int lat);
        @(negedge clk);
        start_valid = 1'b1;
        op_a = a;
        op_b = b;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        op_a = $urandom;
        op_b = $urandom;
        lat = 0;
        while (!res_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic handoff_check(input string name);
        @(posedge clk);
        @(negedge clk);
        check({name, "_ready_after"}, 64'(start_ready), 64'd1);
        check({name, "_valid_after"}, 64'(res_valid), 64'd0);
    endtask

    int          lat;
    bit          seen;
    logic [63:0] held;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset_result", result, 64'd0);
        check("reset_ready",  64'(start_ready), 64'd1);
        check("reset_busy",   64'(busy), 64'd0);
        check("reset_valid",  64'(res_valid), 64'd0);

        // Basic product
        res_ready = 1'b1;
        run_op(32'd3, 32'd5, lat);
        check("basic_latency", 64'(lat), 64'd32);
        check("basic_result",  result, 64'd15);
        handoff_check("basic");
        check("basic_result_held", result, 64'd15);

        // Maximum operands
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        check("max_latency", 64'(lat), 64'd32);
        check("max_result",  result, 64'hFFFF_FFFE_0000_0001);
        handoff_check("max");

        // Zero multiplicand
        run_op(32'd0, 32'h1234, lat);
        check("zero_latency", 64'(lat), 64'd32);
        check("zero_result",  result, 64'd0);
        handoff_check("zero");

        // Odd pattern with carries out of the top half
        run_op(32'h8000_0001, 32'h0000_0003, lat);
        check("carry_result", result, 64'h0000_0001_8000_0003);
        handoff_check("carry");

        // Backpressure with noisy inputs in DONE
        res_ready = 1'b0;
        run_op(32'd1000, 32'd1000, lat);
        check("bp_latency", 64'(lat), 64'd32);
        check("bp_result",  result, 64'd1000000);
        held = result;
        for (int i = 0; i < 10; i++) begin
            start_valid = i[0];
            op_a = $urandom;
            op_b = $urandom;
            @(posedge clk);
            @(negedge clk);
            check("bp_hold_result", result, held);
            check("bp_hold_valid",  64'(res_valid), 64'd1);
            check("bp_hold_ready",  64'(start_ready), 64'd0);
        end
        start_valid = 1'b0;
        res_ready = 1'b1;
        handoff_check("bp");
        check("bp_result_after", result, 64'd1000000);

        // Start requests while busy must not disturb the in-flight product
        @(negedge clk);
        start_valid = 1'b1;
        op_a = 32'd6;
        op_b = 32'd7;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 40 && !res_valid; i++) begin
            op_a = $urandom;
            op_b = $urandom;
            start_valid = (i < 30);
            @(posedge clk);
            @(negedge clk);
        end
        start_valid = 1'b0;
        check("ignore_result", result, 64'd42);
        handoff_check("ignore");

        // Reset at E10 of 7*9
        @(negedge clk);
        start_valid = 1'b1;
        op_a = 32'd7;
        op_b = 32'd9;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ready",  64'(start_ready), 64'd1);
        check("midrst_busy",   64'(busy), 64'd0);
        check("midrst_valid",  64'(res_valid), 64'd0);
        check("midrst_result", result, 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        check("midrst_no_valid", 64'(seen), 64'd0);
        run_op(32'd7, 32'd9, lat);
        check("after_rst_latency", 64'(lat), 64'd32);
        check("after_rst_result",  result, 64'd63);
        handoff_check("after_rst");

        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
